// File: rtl/aes_inv_cipher_top.sv
// aes_inv_cipher_top: iterative AES-128 decryption core.
// The forward key schedule is run for ten cycles to reach the round-10 key,
// then one inverse round is computed per clock while the schedule is walked
// back to the round-0 key. Word ordering: word0 holds bytes 0-3, MSB first.
module aes_inv_cipher_top (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_in,
  input  logic [31:0] ciphertext0_in,
  input  logic [31:0] ciphertext1_in,
  input  logic [31:0] ciphertext2_in,
  input  logic [31:0] ciphertext3_in,
  input  logic [31:0] key0_in,
  input  logic [31:0] key1_in,
  input  logic [31:0] key2_in,
  input  logic [31:0] key3_in,
  output logic [31:0] plaintext0_out,
  output logic [31:0] plaintext1_out,
  output logic [31:0] plaintext2_out,
  output logic [31:0] plaintext3_out,
  output logic        valid_out,
  output logic        busy_out
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEYPREP  = 3'd1,
    INIT_ARK = 3'd2,
    ROUND    = 3'd3,
    FINAL    = 3'd4
  } fsm_t;

  // GF(2^8) multiply by x, reduction polynomial 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply built from an xtime chain
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (x & {8{b[i]}});
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), a);
    end
    return gf_mul(r, r);
  endfunction

  // Forward S-box: inverse followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine map followed by the field inverse
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Row r of the state rotates right by r columns; byte index is 4*col+row
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  fsm_t         fsm_r;
  logic [127:0] blk_r;
  logic [127:0] key_r;
  logic [127:0] pt_r;
  logic [3:0]   rnd_r;
  logic         valid_r;
  logic         busy_r;

  logic [31:0]  sub_in_s;
  logic [31:0]  rot_s;
  logic [31:0]  sub_s;
  logic [7:0]   rcon_s;
  logic [31:0]  nw0_s;
  logic [127:0] key_fwd_s;
  logic [127:0] key_inv_s;
  logic [127:0] isr_s;
  logic [127:0] isb_s;
  logic [127:0] ark_s;
  logic [127:0] imc_s;

  // Shared S-box input: forward step uses w3, backward step uses the recovered previous w3
  always_comb begin
    if (fsm_r == KEYPREP) begin
      sub_in_s = key_r[31:0];
    end else begin
      sub_in_s = key_r[31:0] ^ key_r[63:32];
    end
  end

  assign rot_s  = {sub_in_s[23:0], sub_in_s[31:24]};
  assign rcon_s = rcon(rnd_r);

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    assign sub_s[8*i +: 8] = sbox(rot_s[8*i +: 8]);
  end

  // Word 0 has the same form in both directions; only the S-box input differs
  assign nw0_s     = key_r[127:96] ^ sub_s ^ {rcon_s, 24'h000000};
  assign key_fwd_s = {nw0_s,
                      key_r[95:64] ^ nw0_s,
                      key_r[63:32] ^ key_r[95:64] ^ nw0_s,
                      key_r[31:0]  ^ key_r[63:32] ^ key_r[95:64] ^ nw0_s};
  assign key_inv_s = {nw0_s,
                      key_r[95:64] ^ key_r[127:96],
                      key_r[63:32] ^ key_r[95:64],
                      key_r[31:0]  ^ key_r[63:32]};

  // Inverse round datapath, purely combinational between blk_r and the registers it feeds
  assign isr_s = inv_shift_rows(blk_r);
  for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
    assign isb_s[8*i +: 8] = inv_sbox(isr_s[8*i +: 8]);
  end
  assign ark_s = isb_s ^ key_r;
  assign imc_s = {inv_mix_col(ark_s[127:96]), inv_mix_col(ark_s[95:64]),
                  inv_mix_col(ark_s[63:32]),  inv_mix_col(ark_s[31:0])};

  // Control FSM together with the state, key, counter and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm_r   <= IDLE;
      blk_r   <= 128'h0;
      key_r   <= 128'h0;
      pt_r    <= 128'h0;
      rnd_r   <= 4'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          valid_r <= 1'b0;
          if (start_in) begin
            blk_r  <= {ciphertext0_in, ciphertext1_in, ciphertext2_in, ciphertext3_in};
            key_r  <= {key0_in, key1_in, key2_in, key3_in};
            rnd_r  <= 4'd1;
            busy_r <= 1'b1;
            fsm_r  <= KEYPREP;
          end else begin
            busy_r <= 1'b0;
          end
        end
        KEYPREP: begin
          key_r <= key_fwd_s;
          if (rnd_r == 4'd10) begin
            fsm_r <= INIT_ARK;
          end else begin
            rnd_r <= rnd_r + 4'd1;
          end
        end
        INIT_ARK: begin
          blk_r <= blk_r ^ key_r;
          key_r <= key_inv_s;
          rnd_r <= 4'd9;
          fsm_r <= ROUND;
        end
        ROUND: begin
          blk_r <= imc_s;
          key_r <= key_inv_s;
          if (rnd_r == 4'd1) begin
            fsm_r <= FINAL;
          end else begin
            rnd_r <= rnd_r - 4'd1;
          end
        end
        FINAL: begin
          pt_r    <= ark_s;
          valid_r <= 1'b1;
          rnd_r   <= 4'd0;
          fsm_r   <= IDLE;
        end
        default: begin
          fsm_r <= IDLE;
        end
      endcase
    end
  end

  assign plaintext0_out = pt_r[127:96];
  assign plaintext1_out = pt_r[95:64];
  assign plaintext2_out = pt_r[63:32];
  assign plaintext3_out = pt_r[31:0];
  assign valid_out      = valid_r;
  assign busy_out       = busy_r;

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// Directed bench for aes_inv_cipher_top with a result scoreboard.
// Cycle numbering: the cycle in which start_in is high is cycle 0; the
// plaintext is expected with valid_out in cycle 22 and busy_out high in
// cycles 1..22.
module tb_aes_inv_cipher_top;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start_in;
  logic [31:0] ciphertext0_in, ciphertext1_in, ciphertext2_in, ciphertext3_in;
  logic [31:0] key0_in, key1_in, key2_in, key3_in;
  logic [31:0] plaintext0_out, plaintext1_out, plaintext2_out, plaintext3_out;
  logic        valid_out;
  logic        busy_out;

  aes_inv_cipher_top dut (
    .CLK            (CLK),
    .RST            (RST),
    .start_in       (start_in),
    .ciphertext0_in (ciphertext0_in),
    .ciphertext1_in (ciphertext1_in),
    .ciphertext2_in (ciphertext2_in),
    .ciphertext3_in (ciphertext3_in),
    .key0_in        (key0_in),
    .key1_in        (key1_in),
    .key2_in        (key2_in),
    .key3_in        (key3_in),
    .plaintext0_out (plaintext0_out),
    .plaintext1_out (plaintext1_out),
    .plaintext2_out (plaintext2_out),
    .plaintext3_out (plaintext3_out),
    .valid_out      (valid_out),
    .busy_out       (busy_out)
  );

  always #5 CLK = ~CLK;

  localparam logic [127:0] K_C1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] PT_E1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_E1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT_E2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT_E2  = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] PT_E3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] CT_E3  = 128'h43b1cd7f598ece23881b00e3ed030688;
  localparam logic [127:0] PT_E4  = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] CT_E4  = 128'h7b0c785e27e8ad3f8223207104725dd4;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_total = 0;
  int rd_idx   = 0;

  logic [127:0] got_q[$];
  int           got_cyc_q[$];
  logic [127:0] exp_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Output monitor: logs every valid_out beat and counts busy cycles
  always @(negedge CLK) begin
    if (valid_out) begin
      got_q.push_back({plaintext0_out, plaintext1_out, plaintext2_out, plaintext3_out});
      got_cyc_q.push_back(cyc);
    end
    if (busy_out) busy_total = busy_total + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pt_now();
    return {plaintext0_out, plaintext1_out, plaintext2_out, plaintext3_out};
  endfunction

  task automatic drive_start(input logic [127:0] k, input logic [127:0] ct);
    {ciphertext0_in, ciphertext1_in, ciphertext2_in, ciphertext3_in} = ct;
    {key0_in, key1_in, key2_in, key3_in} = k;
    start_in = 1'b1;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while ((got_q.size() == rd_idx) && (n < 40)) begin
      @(negedge CLK); #1;
      n++;
    end
  endtask

  // Pop the scoreboard and compare against the next logged result
  task automatic take_result(input string tag, input int start_c);
    logic [127:0] e;
    chk_int({tag, " result_count"}, got_q.size() - rd_idx, 1);
    if (got_q.size() > rd_idx) begin
      e = exp_q.pop_front();
      chk({tag, " pt"}, got_q[rd_idx], e);
      chk_int({tag, " latency"}, got_cyc_q[rd_idx] - start_c, 22);
      rd_idx++;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic decrypt(input string tag, input logic [127:0] k, input logic [127:0] ct,
                         input logic [127:0] pt, input bit probe, input logic [127:0] rk10);
    int start_c;
    int busy0;
    int n;
    logic [127:0] key_cap;
    @(negedge CLK); #1;
    drive_start(k, ct);
    exp_q.push_back(pt);
    start_c = cyc;
    busy0 = busy_total;
    key_cap = 128'h0;
    @(negedge CLK); #1;
    start_in = 1'b0;
    n = 0;
    while ((got_q.size() == rd_idx) && (n < 40)) begin
      if (cyc == start_c + 11) key_cap = dut.key_r;
      @(negedge CLK); #1;
      n++;
    end
    take_result(tag, start_c);
    @(negedge CLK); #1;
    chk_int({tag, " busy_cycles"}, busy_total - busy0, 22);
    if (probe) chk({tag, " rk10"}, key_cap, rk10);
  endtask

  initial begin
    int s1;
    int s2;
    RST = 1'b1;
    start_in = 1'b0;
    drive_start(128'h0, 128'h0);
    start_in = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("reset pt", pt_now(), 128'h0);
    chk_int("reset valid", int'(valid_out), 0);
    chk_int("reset busy", int'(busy_out), 0);
    RST = 1'b0;

    // Known-answer decryptions
    decrypt("c1", K_C1, CT_C1, PT_C1, 1'b0, 128'h0);
    decrypt("appb", K_B, CT_B, PT_B, 1'b1, RK10_B);
    decrypt("ecb1", K_B, CT_E1, PT_E1, 1'b0, 128'h0);
    decrypt("ecb2", K_B, CT_E2, PT_E2, 1'b0, 128'h0);
    decrypt("ecb3", K_B, CT_E3, PT_E3, 1'b0, 128'h0);
    decrypt("ecb4", K_B, CT_E4, PT_E4, 1'b0, 128'h0);
    decrypt("zero", 128'h0, CT_Z, 128'h0, 1'b0, 128'h0);

    // start_in pulses at cycles 5 and 15 with other data must be ignored
    @(negedge CLK); #1;
    drive_start(K_C1, CT_C1);
    exp_q.push_back(PT_C1);
    s1 = cyc;
    for (int n = 0; (n < 40) && (got_q.size() == rd_idx); n++) begin
      @(negedge CLK); #1;
      if ((cyc == s1 + 5) || (cyc == s1 + 15)) drive_start(K_B, CT_B);
      else start_in = 1'b0;
    end
    start_in = 1'b0;
    take_result("busy_start", s1);
    repeat (30) @(negedge CLK);
    #1;
    chk_int("busy_start extra_valid", got_q.size() - rd_idx, 0);
    chk("busy_start pt_hold", pt_now(), PT_C1);

    // Back-to-back: second request during the first valid_out cycle
    @(negedge CLK); #1;
    drive_start(K_B, CT_E1);
    exp_q.push_back(PT_E1);
    s1 = cyc;
    @(negedge CLK); #1;
    start_in = 1'b0;
    wait_result();
    drive_start(K_C1, CT_C1);
    exp_q.push_back(PT_C1);
    s2 = cyc;
    chk_int("b2b second_start_cycle", s2 - s1, 22);
    take_result("b2b first", s1);
    @(negedge CLK); #1;
    start_in = 1'b0;
    chk_int("b2b busy_held", int'(busy_out), 1);
    wait_result();
    take_result("b2b second", s2);

    // Reset for one cycle at cycle 12 of a decrypt aborts it
    @(negedge CLK); #1;
    drive_start(K_B, CT_E2);
    s1 = cyc;
    @(negedge CLK); #1;
    start_in = 1'b0;
    while (cyc < s1 + 12) begin
      @(negedge CLK); #1;
    end
    RST = 1'b1;
    @(negedge CLK); #1;
    RST = 1'b0;
    chk("abort pt", pt_now(), 128'h0);
    chk_int("abort valid", int'(valid_out), 0);
    chk_int("abort busy", int'(busy_out), 0);
    repeat (30) @(negedge CLK);
    #1;
    chk_int("abort extra_valid", got_q.size() - rd_idx, 0);
    decrypt("after_abort", K_C1, CT_C1, PT_C1, 1'b0, 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
